hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline controller that sequences the PC and the IF/ID pipeline register.
- Generates PCWrite_en, IF_IDWrite_en, Flush_en and the ID/EX bubble from three sources: load-use hazards, ID-stage redirects (taken branch or jump), and a multi-cycle mult/div unit occupying HI/LO.
- Owns the mult/div busy sequencer and a saturating stall-cycle counter.
- Sits between the ID-stage decoder, the ID/EX register and the IF-stage registers.

Parameters:
- MD_CYCLES, 32, cycles a mult/div occupies HI/LO after issue into EX (legal range 2..64).
- CNT_W, 32, width of the stall performance counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_n  in  1  synchronous active-low reset.
- ID_Rs  in  5  rs field of the instruction in IF/ID.
- ID_Rt  in  5  rt field of the instruction in IF/ID.
- ID_UsesRs  in  1  ID instruction reads rs.
- ID_UsesRt  in  1  ID instruction reads rt.
- ID_HiLoUse  in  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/multu/div/divu.
- ID_Redirect  in  1  taken branch or jump resolved in ID this cycle.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_Rt  in  5  destination of the load in EX.
- ID_EX_MulDiv  in  1  instruction in EX is mult/div; pulses 1 cycle per issue.
- PCWrite_en  out  1  PC may update.
- IF_IDWrite_en  out  1  IF/ID register may load.
- Flush_en  out  1  zero the IF/ID instruction field.
- ID_EX_Bubble  out  1  insert nop into ID/EX.
- MD_Busy  out  1  mult/div result pending.
- MD_Done  out  1  one-cycle pulse when HI/LO becomes valid.
- Stall_Cnt  out  CNT_W  cycles with a stall asserted, saturating.

Behaviour:
- State: FSM {S_RUN, S_MD}, a 6-bit down-counter md_cnt, Stall_Cnt, and a registered MD_Done.
- Reset (RST_n=0 at posedge): state=S_RUN, md_cnt=0, Stall_Cnt=0, MD_Done=0.
  - While RST_n=0, outputs are forced combinationally: PCWrite_en=0, IF_IDWrite_en=0, Flush_en=1, ID_EX_Bubble=1, MD_Busy=0.
  - Reset mid mult/div abandons the operation with no MD_Done.
- Hazard terms (combinational, same cycle):
  - lu_stall = ID_EX_MemRead & ID_EX_Rt!=0 & ((ID_UsesRs & ID_Rs==ID_EX_Rt) | (ID_UsesRt & ID_Rt==ID_EX_Rt)).
  - md_stall = ID_HiLoUse & (state==S_MD).
  - stall = lu_stall | md_stall.
- Outputs (reset released):
  - PCWrite_en = IF_IDWrite_en = ~stall.
  - ID_EX_Bubble = stall.
  - Flush_en = ID_Redirect & ~stall. A stall overrides a redirect because the branch operands are not yet valid; the redirect is re-evaluated when the stall clears.
  - MD_Busy = (state==S_MD).
- FSM transitions:
  - S_RUN with ID_EX_MulDiv=1: go to S_MD, md_cnt <= MD_CYCLES-1.
  - S_MD: md_cnt decrements each cycle. When md_cnt==1, next state is S_RUN and MD_Done is pulsed for the following cycle.
  - MD_Busy is therefore high for exactly MD_CYCLES-1 cycles after the issue edge.
  - ID_EX_MulDiv=1 while in S_MD cannot occur (md_stall holds the next mult/div in ID). If it does occur, the counter reloads to MD_CYCLES-1 and no MD_Done is emitted for the first operation.
- Stall_Cnt increments on each posedge where stall=1, and holds at all-ones (no wrap).
- Latency: every hazard response is 0 cycles (combinational). MD completion is exposed via MD_Done registered one cycle after the counter reaches the end.

Decomposition:
- Shared package: state encodings S_RUN/S_MD, REG_ZERO=5'd0, the MD_CYCLES default.
- One sub-module is natural: md_busy_seq (FSM + md_cnt + MD_Done).
- Hazard compare and counter stay in the top.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=8, ID_Rs=8, ID_UsesRs=1 -> PCWrite_en=0, IF_IDWrite_en=0, ID_EX_Bubble=1 for 1 cycle; Stall_Cnt 0->1. Same with ID_EX_Rt=0 -> no stall.
- Redirect: ID_Redirect=1 with no hazard -> Flush_en=1, PCWrite_en=1. ID_Redirect=1 together with lu_stall -> Flush_en=0 that cycle, Flush_en=1 on the next cycle once the stall clears.
- Mult/div, MD_CYCLES=4: pulse ID_EX_MulDiv at cycle t -> MD_Busy=1 on cycles t+1..t+3, MD_Done=1 on cycle t+4 only.
- HI/LO interlock: mfhi in ID (ID_HiLoUse=1) at cycle t+1 -> stall held through t+3 and released at t+4; Stall_Cnt advances by 3.
- Reset mid-operation: RST_n=0 at the edge after t+2 during S_MD -> MD_Busy=0, Stall_Cnt=0, Flush_en=1 while low; no MD_Done after release.
- Saturation (CNT_W=4): hold stall for 20 cycles -> Stall_Cnt stops at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Pure declarations: no latency and no backpressure of its own.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    S_RUN = 1'b0,
    S_MD  = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         MD_CYCLES_DEF = 32;
  localparam int         MD_CNT_W      = 6;

  // A source operand collides with a producer when it is actually read and the indices agree.
  function automatic logic src_hit(input logic uses, input logic [4:0] src, input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ID-stage / ID/EX / IF-stage signal bundle seen by the hazard controller.
// Wires only: no latency; the controller itself is the backpressure source.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_HiLoUse;
  logic             ID_Redirect;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_Rt;
  logic             ID_EX_MulDiv;

  logic             PCWrite_en;
  logic             IF_IDWrite_en;
  logic             Flush_en;
  logic             ID_EX_Bubble;
  logic             MD_Busy;
  logic             MD_Done;
  logic [CNT_W-1:0] Stall_Cnt;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_HiLoUse, ID_Redirect,
           ID_EX_MemRead, ID_EX_Rt, ID_EX_MulDiv,
    input  PCWrite_en, IF_IDWrite_en, Flush_en, ID_EX_Bubble, MD_Busy, MD_Done, Stall_Cnt
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_HiLoUse, ID_Redirect,
           ID_EX_MemRead, ID_EX_Rt, ID_EX_MulDiv,
    output PCWrite_en, IF_IDWrite_en, Flush_en, ID_EX_Bubble, MD_Busy, MD_Done, Stall_Cnt
  );

endinterface

// File: rtl/hazard_stall_ctrl_md_busy_seq.sv
// Mult/div HI/LO occupancy sequencer: busy for MD_CYCLES-1 cycles after issue, then a done pulse.
// Busy is registered state; done is registered one cycle after the count ends; no backpressure.
module hazard_stall_ctrl_md_busy_seq
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic busy,
  output logic done
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES - 1);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      md_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    done_d   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (issue) begin
          state_d  = S_MD;
          md_cnt_d = MD_LOAD;
        end
      end
      S_MD: begin
        // A second issue while busy restarts the count and drops the first result.
        if (issue) begin
          md_cnt_d = MD_LOAD;
        end else if (md_cnt_q == MD_CNT_W'(1)) begin
          state_d  = S_RUN;
          md_cnt_d = '0;
          done_d   = 1'b1;
        end else begin
          md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d  = S_RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  assign busy = (state_q == S_MD);
  assign done = done_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO interlocks, redirect flush, stall counter.
// Hazard responses are combinational (0 cycles); a stall freezes PC and IF/ID and bubbles ID/EX.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF,
  parameter int CNT_W     = 32
) (
  input  logic               CLK,
  input  logic               RST_n,
  hazard_stall_ctrl_if.slave bus
);

  logic             lu_stall;
  logic             md_stall;
  logic             stall;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  hazard_stall_ctrl_md_busy_seq #(
    .MD_CYCLES(MD_CYCLES)
  ) u_md_busy_seq (
    .clk  (CLK),
    .rst_n(RST_n),
    .issue(bus.ID_EX_MulDiv),
    .busy (md_busy),
    .done (md_done)
  );

  always_comb begin
    lu_stall = bus.ID_EX_MemRead && (bus.ID_EX_Rt != REG_ZERO) &&
               (src_hit(bus.ID_UsesRs, bus.ID_Rs, bus.ID_EX_Rt) ||
                src_hit(bus.ID_UsesRt, bus.ID_Rt, bus.ID_EX_Rt));
    md_stall = bus.ID_HiLoUse && md_busy;
    stall    = lu_stall || md_stall;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Held in reset the pipeline is frozen and flushed regardless of the hazard inputs.
  always_comb begin
    bus.PCWrite_en    = 1'b0;
    bus.IF_IDWrite_en = 1'b0;
    bus.Flush_en      = 1'b1;
    bus.ID_EX_Bubble  = 1'b1;
    bus.MD_Busy       = 1'b0;
    if (RST_n) begin
      bus.PCWrite_en    = !stall;
      bus.IF_IDWrite_en = !stall;
      bus.Flush_en      = bus.ID_Redirect && !stall;
      bus.ID_EX_Bubble  = stall;
      bus.MD_Busy       = md_busy;
    end
  end

  assign bus.MD_Done   = md_done;
  assign bus.Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized and directed bench for hazard_stall_ctrl against a cycle-level reference model.
module tb_hazard_stall_ctrl;

  localparam int MD      = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic RST_n;
  always #5 CLK = ~CLK;

  hazard_stall_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_stall_ctrl #(
    .MD_CYCLES(MD),
    .CNT_W    (CW)
  ) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: remaining HI/LO-busy cycles, pending done pulse, stall count.
  int m_busy_left = 0;
  bit m_done      = 0;
  int m_cnt       = 0;

  int busy_seen = 0;
  int done_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_stall();
    bit lu;
    bit md;
    lu = bus.ID_EX_MemRead && (bus.ID_EX_Rt != 5'd0) &&
         ((bus.ID_UsesRs && (bus.ID_Rs == bus.ID_EX_Rt)) ||
          (bus.ID_UsesRt && (bus.ID_Rt == bus.ID_EX_Rt)));
    md = bus.ID_HiLoUse && (m_busy_left > 0);
    return lu || md;
  endfunction

  task automatic check_outputs();
    bit st;
    st = exp_stall();
    if (!RST_n) begin
      check("rst_pcwrite", bus.PCWrite_en, 0);
      check("rst_ifid", bus.IF_IDWrite_en, 0);
      check("rst_flush", bus.Flush_en, 1);
      check("rst_bubble", bus.ID_EX_Bubble, 1);
      check("rst_busy", bus.MD_Busy, 0);
    end else begin
      check("pcwrite", bus.PCWrite_en, !st);
      check("ifid", bus.IF_IDWrite_en, !st);
      check("flush", bus.Flush_en, bus.ID_Redirect && !st);
      check("bubble", bus.ID_EX_Bubble, st);
      check("md_busy", bus.MD_Busy, m_busy_left > 0);
    end
    check("md_done", bus.MD_Done, m_done);
    check("stall_cnt", bus.Stall_Cnt, m_cnt);
    busy_seen += int'(bus.MD_Busy);
    done_seen += int'(bus.MD_Done);
  endtask

  task automatic model_edge();
    bit st;
    if (!RST_n) begin
      m_busy_left = 0;
      m_done      = 0;
      m_cnt       = 0;
    end else begin
      st     = exp_stall();
      m_done = (m_busy_left == 1) && !bus.ID_EX_MulDiv;
      if (bus.ID_EX_MulDiv) m_busy_left = MD - 1;
      else if (m_busy_left > 0) m_busy_left--;
      if (st && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic cycle();
    @(negedge CLK);
    check_outputs();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.ID_Rs         = 5'd0;
    bus.ID_Rt         = 5'd0;
    bus.ID_UsesRs     = 1'b0;
    bus.ID_UsesRt     = 1'b0;
    bus.ID_HiLoUse    = 1'b0;
    bus.ID_Redirect   = 1'b0;
    bus.ID_EX_MemRead = 1'b0;
    bus.ID_EX_Rt      = 5'd0;
    bus.ID_EX_MulDiv  = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    bus.ID_EX_MemRead = 1'b1;
    bus.ID_EX_Rt      = r;
    bus.ID_Rs         = r;
    bus.ID_UsesRs     = 1'b1;
  endtask

  task automatic do_reset();
    RST_n = 1'b0;
    idle();
    cycle();
    RST_n = 1'b1;
  endtask

  int cnt0;

  initial begin
    RST_n = 1'b0;
    idle();
    @(posedge CLK);
    model_edge();
    #1;
    cycle();
    check("rst_cnt_zero", bus.Stall_Cnt, 0);
    RST_n = 1'b1;

    // Load-use on r8, then the same shape against r0.
    set_lu(5'd8);
    cycle();
    check("lu_cnt", bus.Stall_Cnt, 1);
    idle();
    set_lu(5'd0);
    cycle();
    check("lu_r0_cnt", bus.Stall_Cnt, 1);

    // Redirect alone, redirect under a stall, then redirect once the stall clears.
    idle();
    bus.ID_Redirect = 1'b1;
    cycle();
    set_lu(5'd9);
    cycle();
    idle();
    bus.ID_Redirect = 1'b1;
    cycle();

    // Mult/div issue with mfhi waiting behind it.
    do_reset();
    bus.ID_EX_MulDiv = 1'b1;
    cycle();
    bus.ID_EX_MulDiv = 1'b0;
    bus.ID_HiLoUse   = 1'b1;
    busy_seen = 0;
    done_seen = 0;
    cnt0 = int'(bus.Stall_Cnt);
    repeat (3) cycle();
    check("md_busy_len", busy_seen, 3);
    check("md_hilo_stall", int'(bus.Stall_Cnt) - cnt0, 3);
    cycle();
    idle();
    cycle();
    check("md_done_once", done_seen, 1);

    // Reset during the mult/div: no done afterwards.
    do_reset();
    bus.ID_EX_MulDiv = 1'b1;
    cycle();
    bus.ID_EX_MulDiv = 1'b0;
    bus.ID_HiLoUse   = 1'b1;
    repeat (2) cycle();
    RST_n = 1'b0;
    cycle();
    RST_n = 1'b1;
    check("md_rst_cnt", bus.Stall_Cnt, 0);
    busy_seen = 0;
    done_seen = 0;
    repeat (6) cycle();
    check("md_rst_no_done", done_seen, 0);
    check("md_rst_no_busy", busy_seen, 0);

    // Saturation.
    idle();
    set_lu(5'd5);
    repeat (20) cycle();
    check("sat_cnt", bus.Stall_Cnt, CNT_MAX);

    // Random traffic with a small register pool to provoke matches.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      RST_n             = ($urandom_range(0, 59) != 0);
      bus.ID_Rs         = 5'($urandom_range(0, 3));
      bus.ID_Rt         = 5'($urandom_range(0, 3));
      bus.ID_UsesRs     = 1'($urandom_range(0, 1));
      bus.ID_UsesRt     = 1'($urandom_range(0, 1));
      bus.ID_HiLoUse    = ($urandom_range(0, 2) == 0);
      bus.ID_Redirect   = ($urandom_range(0, 3) == 0);
      bus.ID_EX_MemRead = ($urandom_range(0, 2) == 0);
      bus.ID_EX_Rt      = 5'($urandom_range(0, 3));
      bus.ID_EX_MulDiv  = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
